f1_reaction_timer: RTL and testbench

Parametrised F1 start-light sequencer and reaction timer. It replaces the fixed 10-light FSM, the separate tick dividers and the LFSR delay with one self-contained block. It lights N_LIGHTS lamps one per step, holds them for a pseudo-random time, then extinguishes them and measures the driver's reaction in milliseconds. It also detects jump starts. It sits between debounced/synchronised KEY inputs and the LEDR / BCD display path.

---
 rtl/f1_reaction_timer.sv | 179 +++++++++++++++++
 tb/tb_f1_reaction_timer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/f1_reaction_timer.sv
// F1 start-light sequencer and reaction timer: lights lamps one per step, holds for a
// pseudo-random time, then times the driver's button press in milliseconds.
module f1_reaction_timer #(
    parameter int unsigned N_LIGHTS      = 10,
    parameter int unsigned TICK_DIV      = 50000,
    parameter int unsigned STEP_MS       = 500,
    parameter int unsigned LFSR_W        = 7,
    parameter int unsigned HOLD_SCALE_MS = 16,
    parameter int unsigned CNT_W         = 14,
    parameter int unsigned MAX_REACT_MS  = 9999
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                trigger,
    input  logic                react,
    output logic [N_LIGHTS-1:0] ledr,
    output logic [CNT_W-1:0]    react_ms,
    output logic                valid,
    output logic                jump_start,
    output logic                busy,
    output logic                ms_tick
);
    localparam int unsigned PRE_W  = $clog2(TICK_DIV);
    localparam int unsigned STEP_W = $clog2(STEP_MS + 1);
    localparam int unsigned HOLD_W = LFSR_W + $clog2(HOLD_SCALE_MS + 1);

    // Feedback tap masks (bit n of the polynomial maps to mask bit n-1)
    localparam logic [7:0] TAP_MASK = (LFSR_W == 4) ? 8'h0C :
                                      (LFSR_W == 5) ? 8'h14 :
                                      (LFSR_W == 6) ? 8'h30 :
                                      (LFSR_W == 7) ? 8'h60 : 8'hB8;

    localparam logic [PRE_W-1:0]    PRE_LAST     = PRE_W'(TICK_DIV - 1);
    localparam logic [STEP_W-1:0]   STEP_LAST    = STEP_W'(STEP_MS - 1);
    localparam logic [CNT_W-1:0]    REACT_MAX    = CNT_W'(MAX_REACT_MS);
    localparam logic [CNT_W-1:0]    REACT_PENULT = CNT_W'(MAX_REACT_MS - 1);
    localparam logic [N_LIGHTS-1:0] LEDR_ONE     = N_LIGHTS'(1);
    localparam logic [HOLD_W-1:0]   HOLD_ONE     = HOLD_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LIGHTS,
        S_HOLD,
        S_TIMING,
        S_DONE,
        S_FAULT
    } state_e;

    state_e              state_q, state_d;
    logic                trig_prev_q, react_prev_q;
    logic [PRE_W-1:0]    presc_q, presc_d;
    logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [N_LIGHTS-1:0] ledr_q, ledr_d, ledr_shift;
    logic [CNT_W-1:0]    react_q, react_d;
    logic                valid_q, jump_q, busy_q;
    logic                trig_edge, react_edge, tick, step_done;

    assign trig_edge  = trigger & ~trig_prev_q;
    assign react_edge = react & ~react_prev_q;
    assign tick       = (presc_q == PRE_LAST);
    assign step_done  = tick && (step_q == STEP_LAST);
    assign ledr_shift = (ledr_q << 1) | LEDR_ONE;
    assign lfsr_d     = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & TAP_MASK[LFSR_W-1:0])};

    assign ledr       = ledr_q;
    assign react_ms   = react_q;
    assign valid      = valid_q;
    assign jump_start = jump_q;
    assign busy       = busy_q;
    assign ms_tick    = tick;

    // Next-state and datapath decode; react beats a same-cycle tick everywhere
    always_comb begin
        state_d = state_q;
        presc_d = tick ? '0 : presc_q + PRE_W'(1);
        step_d  = step_q;
        hold_d  = hold_q;
        ledr_d  = ledr_q;
        react_d = react_q;
        case (state_q)
            S_IDLE, S_DONE, S_FAULT: begin
                if (trig_edge) begin
                    state_d = S_LIGHTS;
                    ledr_d  = LEDR_ONE;
                    step_d  = '0;
                    presc_d = '0;
                    react_d = '0;
                end else if (state_q == S_FAULT && tick) begin
                    if (step_done) begin
                        ledr_d = ~ledr_q;
                        step_d = '0;
                    end else begin
                        step_d = step_q + STEP_W'(1);
                    end
                end
            end
            S_LIGHTS: begin
                if (react_edge) begin
                    state_d = S_FAULT;
                    ledr_d  = '1;
                    step_d  = '0;
                end else if (tick) begin
                    if (step_done) begin
                        ledr_d = ledr_shift;
                        step_d = '0;
                        if (ledr_shift[N_LIGHTS-1]) begin
                            state_d = S_HOLD;
                            hold_d  = HOLD_W'(lfsr_q) * HOLD_W'(HOLD_SCALE_MS);
                        end
                    end else begin
                        step_d = step_q + STEP_W'(1);
                    end
                end
            end
            S_HOLD: begin
                if (react_edge) begin
                    state_d = S_FAULT;
                    ledr_d  = '1;
                    step_d  = '0;
                end else if (tick) begin
                    if (hold_q == HOLD_ONE) begin
                        state_d = S_TIMING;
                        ledr_d  = '0;
                        react_d = '0;
                    end else begin
                        hold_d = hold_q - HOLD_ONE;
                    end
                end
            end
            S_TIMING: begin
                if (react_edge) begin
                    state_d = S_DONE;
                end else if (tick) begin
                    if (react_q >= REACT_PENULT) begin
                        react_d = REACT_MAX;
                        state_d = S_DONE;
                    end else begin
                        react_d = react_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, datapath and registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            trig_prev_q  <= 1'b1;
            react_prev_q <= 1'b1;
            presc_q      <= '0;
            lfsr_q       <= LFSR_W'(1);
            step_q       <= '0;
            hold_q       <= '0;
            ledr_q       <= '0;
            react_q      <= '0;
            valid_q      <= 1'b0;
            jump_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            trig_prev_q  <= trigger;
            react_prev_q <= react;
            presc_q      <= presc_d;
            lfsr_q       <= lfsr_d;
            step_q       <= step_d;
            hold_q       <= hold_d;
            ledr_q       <= ledr_d;
            react_q      <= react_d;
            valid_q      <= (state_d == S_DONE);
            jump_q       <= (state_d == S_FAULT);
            busy_q       <= (state_d == S_LIGHTS) || (state_d == S_HOLD) ||
                            (state_d == S_TIMING);
        end
    end
endmodule

// File: tb/tb_f1_reaction_timer.sv
// Bench for f1_reaction_timer with small parameters: timed expectations are queued when
// stimulus is driven and compared when their cycle arrives.
module tb_f1_reaction_timer;
    localparam int unsigned N  = 4;
    localparam int unsigned TD = 4;
    localparam int unsigned SM = 2;
    localparam int unsigned LW = 4;
    localparam int unsigned HS = 1;
    localparam int unsigned CW = 14;
    localparam int unsigned MX = 50;

    localparam logic [5:0] M_OUT = 6'b011111;
    localparam logic [5:0] M_ALL = 6'b111111;
    localparam logic [5:0] M_LJB = 6'b011001;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          trigger = 1'b0;
    logic          react = 1'b0;
    logic [N-1:0]  ledr;
    logic [CW-1:0] react_ms;
    logic          valid, jump_start, busy, ms_tick;

    f1_reaction_timer #(
        .N_LIGHTS(N), .TICK_DIV(TD), .STEP_MS(SM), .LFSR_W(LW),
        .HOLD_SCALE_MS(HS), .CNT_W(CW), .MAX_REACT_MS(MX)
    ) dut (
        .clk(clk), .rst(rst), .trigger(trigger), .react(react),
        .ledr(ledr), .react_ms(react_ms), .valid(valid),
        .jump_start(jump_start), .busy(busy), .ms_tick(ms_tick)
    );

    always #5 clk = ~clk;

    // Reference LFSR (x^4 + x^3 + 1), seeded 1 on reset
    logic [LW-1:0] m_lfsr;
    always @(posedge clk) begin
        if (rst) m_lfsr <= LW'(1);
        else     m_lfsr <= {m_lfsr[LW-2:0], m_lfsr[3] ^ m_lfsr[2]};
    end

    typedef struct {
        string      name;
        int         due;
        logic [5:0] mask;
        logic [3:0] ledr;
        int         rms;
        logic       valid;
        logic       jump;
        logic       busy;
        logic       tick;
    } exp_t;

    typedef struct {
        string      name;
        int         off;
        logic [3:0] ledr;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[7];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   t, h, lo, tf, nticks;

    task automatic push(input string name, input int due, input logic [5:0] mask,
                        input logic [3:0] l, input int r, input logic v,
                        input logic j, input logic b, input logic tk);
        exp_t e;
        int   i;
        e.name = name; e.due = due; e.mask = mask; e.ledr = l; e.rms = r;
        e.valid = v; e.jump = j; e.busy = b; e.tick = tk;
        i = 0;
        while (i < sb.size() && sb[i].due <= due) i++;
        sb.insert(i, e);
    endtask

    task automatic service();
        exp_t e;
        logic bad;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            checks++;
            bad = 1'b0;
            if (e.due < cyc) bad = 1'b1;
            if (e.mask[0] && ledr !== e.ledr) bad = 1'b1;
            if (e.mask[1] && react_ms !== CW'(e.rms)) bad = 1'b1;
            if (e.mask[2] && valid !== e.valid) bad = 1'b1;
            if (e.mask[3] && jump_start !== e.jump) bad = 1'b1;
            if (e.mask[4] && busy !== e.busy) bad = 1'b1;
            if (e.mask[5] && ms_tick !== e.tick) bad = 1'b1;
            if (bad) begin
                errors++;
                $display("FAIL %s at cycle %0d (due %0d): got ledr=%b react_ms=%0d valid=%b jump=%b busy=%b tick=%b, required ledr=%b react_ms=%0d valid=%b jump=%b busy=%b tick=%b mask=%b",
                         e.name, cyc, e.due, ledr, react_ms, valid, jump_start, busy, ms_tick,
                         e.ledr, e.rms, e.valid, e.jump, e.busy, e.tick, e.mask);
            end
        end
    endtask

    task automatic advance(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            service();
        end
    endtask

    task automatic advance_to(input int c);
        while (cyc < c) advance(1);
    endtask

    // Trigger edge now; queue the lamp table; return at T+25 with the hold length in ms
    task automatic start_run(output int t0, output int h0);
        t0 = cyc;
        trigger = 1'b1;
        for (int i = 0; i < 7; i++)
            push(vecs[i].name, t0 + vecs[i].off, M_OUT, vecs[i].ledr, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        advance(1);
        trigger = 1'b0;
        advance_to(t0 + 24);
        h0 = int'(m_lfsr) * int'(HS);
        advance(1);
    endtask

    initial begin
        vecs[0] = '{"lamp1_on",     1,  4'b0001};
        vecs[1] = '{"lamp1_before", 8,  4'b0001};
        vecs[2] = '{"lamp2_on",     9,  4'b0011};
        vecs[3] = '{"lamp2_before", 16, 4'b0011};
        vecs[4] = '{"lamp3_on",     17, 4'b0111};
        vecs[5] = '{"lamp3_before", 24, 4'b0111};
        vecs[6] = '{"lamp4_on",     25, 4'b1111};

        // Reset with trigger held high: no sequence may start afterwards
        rst = 1'b1; trigger = 1'b1; react = 1'b0;
        advance(3);
        push("reset_state", cyc + 1, M_ALL, 4'b0000, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        advance(1);
        rst = 1'b0;
        push("held_trigger_no_start", cyc + 20, M_OUT, 4'b0000, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        advance(20);
        nticks = 0;
        for (int i = 0; i < 40; i++) begin
            advance(1);
            if (ms_tick) nticks++;
        end
        checks++;
        if (nticks != 10) begin
            errors++;
            $display("FAIL ms_tick_rate: got %0d ticks in 40 cycles, required 10", nticks);
        end
        trigger = 1'b0;
        advance(2);

        // Run 1: full sequence, react at 7 ms, further react ignored
        start_run(t, h);
        lo = t + 25 + 4 * h;
        push("hold_lamps_on", lo - 1, M_OUT, 4'b1111, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        push("lights_out",    lo,     M_OUT, 4'b0000, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        push("timing_rms6",   lo + 27, M_OUT, 4'b0000, 6, 1'b0, 1'b0, 1'b1, 1'b0);
        push("timing_rms7",   lo + 28, M_OUT, 4'b0000, 7, 1'b0, 1'b0, 1'b1, 1'b0);
        advance_to(lo + 29);
        react = 1'b1;
        push("done_rms7", lo + 30, M_OUT, 4'b0000, 7, 1'b1, 1'b0, 1'b0, 1'b0);
        advance(2);
        react = 1'b0;
        advance(3);
        react = 1'b1;
        push("second_react_ignored", cyc + 6, M_OUT, 4'b0000, 7, 1'b1, 1'b0, 1'b0, 1'b0);
        advance(6);
        react = 1'b0;
        advance(2);

        // Run 2: trigger ignored in TIMING, react coincident with a tick at 3 ms
        start_run(t, h);
        lo = t + 25 + 4 * h;
        push("lights_out_2", lo, M_OUT, 4'b0000, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        advance_to(lo + 5);
        push("trigger_ignored_timing", lo + 6, M_OUT, 4'b0000, 1, 1'b0, 1'b0, 1'b1, 1'b0);
        push("tick_with_rms3", lo + 15, 6'b100011, 4'b0000, 3, 1'b0, 1'b0, 1'b1, 1'b1);
        trigger = 1'b1;
        advance(1);
        trigger = 1'b0;
        advance_to(lo + 15);
        react = 1'b1;
        push("react_beats_tick", lo + 16, M_OUT, 4'b0000, 3, 1'b1, 1'b0, 1'b0, 1'b0);
        advance(1);
        react = 1'b0;
        advance(2);

        // Run 3: jump start at lamp 2, FAULT blink, restart with trigger+react, rst in HOLD
        t = cyc;
        trigger = 1'b1;
        push("restart_clears_rms", t + 1, M_OUT, 4'b0001, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        advance(1);
        trigger = 1'b0;
        advance_to(t + 10);
        react = 1'b1;
        push("fault_entry", t + 11, M_OUT, 4'b1111, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        advance(1);
        react = 1'b0;
        push("fault_on_a",  t + 16, M_LJB, 4'b1111, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        push("fault_off_a", t + 17, M_LJB, 4'b0000, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        push("fault_off_b", t + 24, M_LJB, 4'b0000, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        push("fault_on_b",  t + 25, M_LJB, 4'b1111, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        push("fault_off_c", t + 33, M_LJB, 4'b0000, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        advance_to(t + 36);
        tf = cyc;
        trigger = 1'b1;
        react = 1'b1;
        push("trigger_wins_fault", tf + 1, M_OUT, 4'b0001, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        push("react_discarded",    tf + 2, M_OUT, 4'b0001, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        advance(1);
        trigger = 1'b0;
        advance(1);
        react = 1'b0;
        advance_to(tf + 26);
        rst = 1'b1;
        push("reset_mid_hold", tf + 27, M_ALL, 4'b0000, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        advance(1);
        rst = 1'b0;
        advance(2);

        // Run 4: react on the HOLD->TIMING edge counts as a jump start
        start_run(t, h);
        lo = t + 25 + 4 * h;
        advance_to(lo - 1);
        react = 1'b1;
        push("react_at_lights_out", lo, M_OUT, 4'b1111, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        advance(1);
        react = 1'b0;
        advance(2);

        // Run 5: no react, saturate at MAX_REACT_MS without wrapping
        start_run(t, h);
        lo = t + 25 + 4 * h;
        push("lights_out_5", lo,       M_OUT, 4'b0000, 0,  1'b0, 1'b0, 1'b1, 1'b0);
        push("rms49",        lo + 199, M_OUT, 4'b0000, 49, 1'b0, 1'b0, 1'b1, 1'b0);
        push("saturate50",   lo + 200, M_OUT, 4'b0000, 50, 1'b1, 1'b0, 1'b0, 1'b0);
        push("no_wrap",      lo + 600, M_OUT, 4'b0000, 50, 1'b1, 1'b0, 1'b0, 1'b0);
        advance_to(lo + 601);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expectations, required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
